uart_autobaud: RTL and testbench
================================

# uart_autobaud

Automatic baud-rate detector on the UART receive pin. Software arms it and has the remote end send the sync character 0x55 ('U'). The block measures the character's bit timing in `clk_i` cycles and produces a divider value in the same units as the UART's `CLK_DIV` register. It sits beside the UART receive path, observes the same `rx_i` pin, and its `div_o` result is written by software into `CLK_DIV` before enabling the UART clock.

## Interface
- `CNT_WIDTH`, default 20: width of the interval counters; sets the slowest measurable rate.
- `DATA_WIDTH`, default 32: width of `div_o`.
- `MIN_DIV`, default 16: smallest acceptable result. The receive path oversamples at divider >> 3, so smaller values are rejected.

- `clk_i`, input, 1: system clock.
- `arst_ni`, input, 1: asynchronous active-low reset.
- `rx_i`, input, 1: raw UART pin, asynchronous to `clk_i`.
- `start_i`, input, 1: single-cycle arm request.
- `abort_i`, input, 1: cancel measurement and return to IDLE.
- `busy_o`, output, 1: high from arm until done, error or abort.
- `done_o`, output, 1: single-cycle pulse when a valid result is produced.
- `error_o`, output, 1: single-cycle pulse when measurement fails.
- `div_o`, output, `DATA_WIDTH`: measured clock cycles per bit, zero-extended.
- `div_valid_o`, output, 1: sticky; set with `done_o`, cleared on the next accepted `start_i`.

## Operation
- **Input conditioning:** `rx_i` passes through a 2-flop synchronizer and then an edge-detect register. All three flops reset to 1 (idle line).
- **Waveform measured:** 0x55 on the line is start 0, then 1 0 1 0 1 0 1 0, then stop 1. Falling edges occur at bit times 0, 2, 4, 6 and 8.
  - T is the number of cycles between detection of falling edge 1 and falling edge 5, which equals 8 bit periods.
  - `div_o` = (T + 4) >> 3, i.e. rounded to nearest.
- **States:**
  - IDLE: `start_i` → ARM. `div_valid_o` clears.
  - ARM: wait until the synchronized rx is 1, then → HUNT.
  - HUNT: on a falling edge, clear the counters, set edge index to 1 → MEAS.
  - MEAS: the total counter and segment counter increment every cycle; rising edges within the current segment are counted.
    - On a falling edge, the segment length (cycles since the previous falling edge) must contain exactly one rising edge, otherwise → ERR.
    - Segment 1 length is stored as `ref`. Segments 2–4 must satisfy |seg − ref| ≤ ref >> 3, otherwise → ERR.
    - After the 4th segment → EVAL.
  - EVAL: compute `div_o`. If `div_o` < `MIN_DIV` → ERR. Otherwise load `div_o`, set `div_valid_o`, pulse `done_o`, → IDLE.
  - ERR: pulse `error_o`, → IDLE. `div_o` and `div_valid_o` keep their previous values.
- **Timeout:** if the segment counter reaches 2^`CNT_WIDTH` − 1 in MEAS → ERR. Counters never wrap. HUNT has no timeout; software uses `abort_i`.
- **Control priority:**
  - `abort_i` takes priority in every state: → IDLE next cycle, no pulses, `div_o` unchanged.
  - `start_i` outside IDLE is ignored.
  - `start_i` and `abort_i` in the same cycle from IDLE: abort wins, so the block stays IDLE.
- **Reset mid-operation:** everything returns to reset values immediately.
  - Reset values: `busy_o` 0, `done_o` 0, `error_o` 0, `div_o` 0, `div_valid_o` 0, state IDLE.

## Timing
- `rx_i` to edge detection latency is a constant 3 cycles. It cancels in every interval, so measured lengths are exact in cycles of detection.
- `busy_o` rises the cycle after an accepted `start_i` and falls in the same cycle `done_o` or `error_o` is high.
- 5th falling-edge detection to EVAL: 1 cycle. EVAL to `done_o`/`error_o` high: 1 cycle.
  - `div_o` and `div_valid_o` update in the same cycle as `done_o`.
- Total counter width is `CNT_WIDTH` + 2, so 4 maximal segments cannot overflow.

## Test plan
- 0x55 at exactly 100 cycles/bit → `done_o` once, `div_o` = 100, `div_valid_o` = 1, `busy_o` low that cycle.
- Bit widths alternating 100/101 cycles with T = 803 → `div_o` = 100 (rounded). With T = 868 × 8 = 6944 → `div_o` = 868.
- 0x53 at 100 cycles/bit (segment tolerance / rising-edge count violated) → `error_o` pulse. `div_o` and `div_valid_o` keep their prior values.
- 0x55 at 12 cycles/bit → `error_o` (`div_o` would be 12, below `MIN_DIV` 16). A 1-cycle low glitch inside segment 2 at 100 cycles/bit → `error_o`.
- `CNT_WIDTH` = 8, line held low after the first falling edge → `error_o` after 255 cycles in MEAS. `abort_i` during MEAS → IDLE with no pulse.
- `arst_ni` asserted mid-MEAS → all outputs 0 immediately. Re-arming after release with a clean 0x55 at 50 cycles/bit → `div_o` = 50.

Source files
------------

// File: rtl/uart_autobaud.sv
// Autobaud detector: times the four falling-edge segments of a 0x55 sync
// character on rx_i and reports the rounded clock-cycles-per-bit divider.
module uart_autobaud #(
  parameter int CNT_WIDTH  = 20,
  parameter int DATA_WIDTH = 32,
  parameter int MIN_DIV    = 16
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  rx_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [DATA_WIDTH-1:0] div_o,
  output logic                  div_valid_o
);

  localparam int TW = CNT_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] SEG_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] MIN_DIV_C = CNT_WIDTH'(MIN_DIV);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_HUNT = 3'd2;
  localparam logic [2:0] S_MEAS = 3'd3;
  localparam logic [2:0] S_EVAL = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic                  rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic [CNT_WIDTH-1:0]  seg_q, seg_d, ref_q, ref_d;
  logic [TW-1:0]         tot_q, tot_d;
  logic [1:0]            rise_q, rise_d;
  logic [2:0]            edge_q, edge_d;
  logic                  busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [DATA_WIDTH-1:0] div_q, div_d;
  logic                  div_valid_q, div_valid_d;

  logic                  fall_s, rise_s;
  logic [TW:0]           round_s;
  logic [CNT_WIDTH-1:0]  div_calc_s;

  // Segment is accepted when it deviates from the reference by at most ref/8.
  function automatic logic within_tol(input logic [CNT_WIDTH-1:0] seg,
                                      input logic [CNT_WIDTH-1:0] r);
    logic [CNT_WIDTH-1:0] diff;
    diff = (seg > r) ? (seg - r) : (r - seg);
    return diff <= (r >> 3);
  endfunction

  assign fall_s     = rx_prev_q & ~rx_s2_q;
  assign rise_s     = ~rx_prev_q & rx_s2_q;
  assign round_s    = {1'b0, tot_q} + {{(TW - 2){1'b0}}, 3'd4};
  assign div_calc_s = round_s[TW:3];

  // Next-state and datapath; counters start at 1 so a captured value is the full interval.
  always_comb begin
    state_d     = state_q;
    rx_s1_d     = rx_i;
    rx_s2_d     = rx_s1_q;
    rx_prev_d   = rx_s2_q;
    seg_d       = seg_q;
    ref_d       = ref_q;
    tot_d       = tot_q;
    rise_d      = rise_q;
    edge_d      = edge_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    div_d       = div_q;
    div_valid_d = div_valid_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_ARM;
          busy_d      = 1'b1;
          div_valid_d = 1'b0;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_ARM: begin
        if (rx_s2_q) begin
          state_d = S_HUNT;
        end else begin
          state_d = S_ARM;
        end
      end
      S_HUNT: begin
        if (fall_s) begin
          seg_d   = {{(CNT_WIDTH - 1){1'b0}}, 1'b1};
          tot_d   = {{(TW - 1){1'b0}}, 1'b1};
          rise_d  = 2'd0;
          edge_d  = 3'd1;
          state_d = S_MEAS;
        end else begin
          state_d = S_HUNT;
        end
      end
      S_MEAS: begin
        if (fall_s) begin
          if ((rise_q != 2'd1) || ((edge_q != 3'd1) && !within_tol(seg_q, ref_q))) begin
            state_d = S_ERR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            if (edge_q == 3'd1) begin
              ref_d = seg_q;
            end else begin
              ref_d = ref_q;
            end
            seg_d  = {{(CNT_WIDTH - 1){1'b0}}, 1'b1};
            rise_d = 2'd0;
            edge_d = edge_q + 3'd1;
            if (edge_q == 3'd4) begin
              state_d = S_EVAL;
            end else begin
              tot_d = tot_q + {{(TW - 1){1'b0}}, 1'b1};
            end
          end
        end else if (seg_q == SEG_MAX) begin
          state_d = S_ERR;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          seg_d = seg_q + {{(CNT_WIDTH - 1){1'b0}}, 1'b1};
          tot_d = tot_q + {{(TW - 1){1'b0}}, 1'b1};
          if (rise_s && (rise_q != 2'd2)) begin
            rise_d = rise_q + 2'd1;
          end else begin
            rise_d = rise_q;
          end
        end
      end
      S_EVAL: begin
        busy_d = 1'b0;
        if (div_calc_s < MIN_DIV_C) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          div_d       = DATA_WIDTH'(div_calc_s);
          div_valid_d = 1'b1;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Abort overrides everything, including a same-cycle start from IDLE.
    if (abort_i) begin
      state_d     = S_IDLE;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      error_d     = 1'b0;
      div_d       = div_q;
      div_valid_d = div_valid_q;
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers; the rx pipeline resets to the idle-line level.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= S_IDLE;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      seg_q       <= {CNT_WIDTH{1'b0}};
      ref_q       <= {CNT_WIDTH{1'b0}};
      tot_q       <= {TW{1'b0}};
      rise_q      <= 2'd0;
      edge_q      <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      div_q       <= {DATA_WIDTH{1'b0}};
      div_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_prev_q   <= rx_prev_d;
      seg_q       <= seg_d;
      ref_q       <= ref_d;
      tot_q       <= tot_d;
      rise_q      <= rise_d;
      edge_q      <= edge_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      div_q       <= div_d;
      div_valid_q <= div_valid_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign div_o       = div_q;
  assign div_valid_o = div_valid_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: expected results are queued as each frame
// is sent and compared whenever the DUT pulses done_o or error_o.
module tb_uart_autobaud;

  typedef struct {
    logic        is_done;
    logic [31:0] div;
    logic        valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        arst_ni, rx, start, abort;
  logic        busy_o, done_o, error_o, div_valid_o;
  logic [31:0] div_o;
  logic        s_rx, s_start, s_abort;
  logic        s_busy, s_done, s_error, s_valid;
  logic [31:0] s_div;

  int   checks = 0;
  int   passes = 0;
  int   bw[10];
  exp_t q[$];
  exp_t qs[$];

  always #5 clk = ~clk;

  uart_autobaud #(.CNT_WIDTH(20), .DATA_WIDTH(32), .MIN_DIV(16)) u_dut (
    .clk_i(clk), .arst_ni(arst_ni), .rx_i(rx), .start_i(start), .abort_i(abort),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .div_o(div_o),
    .div_valid_o(div_valid_o)
  );

  uart_autobaud #(.CNT_WIDTH(8), .DATA_WIDTH(32), .MIN_DIV(16)) u_small (
    .clk_i(clk), .arst_ni(arst_ni), .rx_i(s_rx), .start_i(s_start), .abort_i(s_abort),
    .busy_o(s_busy), .done_o(s_done), .error_o(s_error), .div_o(s_div),
    .div_valid_o(s_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    exp_t ex;
    if (done_o || error_o) begin
      if (q.size() == 0) begin
        chk("main_unexpected_pulse", {30'd0, done_o, error_o}, 32'd0);
      end else begin
        ex = q.pop_front();
        chk("main_done", 32'(done_o), 32'(ex.is_done));
        chk("main_error", 32'(error_o), 32'(!ex.is_done));
        chk("main_div", div_o, ex.div);
        chk("main_valid", 32'(div_valid_o), 32'(ex.valid));
        chk("main_busy_at_pulse", 32'(busy_o), 32'd0);
      end
    end
    if (s_done || s_error) begin
      if (qs.size() == 0) begin
        chk("small_unexpected_pulse", {30'd0, s_done, s_error}, 32'd0);
      end else begin
        ex = qs.pop_front();
        chk("small_done", 32'(s_done), 32'(ex.is_done));
        chk("small_error", 32'(s_error), 32'(!ex.is_done));
        chk("small_div", s_div, ex.div);
        chk("small_busy_at_pulse", 32'(s_busy), 32'd0);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic push(input logic is_done, input logic [31:0] div, input logic valid);
    exp_t ex;
    ex.is_done = is_done;
    ex.div     = div;
    ex.valid   = valid;
    q.push_back(ex);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && (q.size() + qs.size()) > 0; i++) tick();
    chk("result_timeout", 32'(q.size() + qs.size()), 32'd0);
    q.delete();
    qs.delete();
  endtask

  task automatic set_bw(input int w);
    for (int i = 0; i < 10; i++) bw[i] = w;
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_arm", 32'(busy_o), 32'd1);
    chk("valid_cleared_on_arm", 32'(div_valid_o), 32'd0);
    tick();
    tick();
  endtask

  // Glitch is a cycle offset within the frame that is forced low (-1: none).
  task automatic send_frame(input logic [7:0] data, input int glitch);
    logic [9:0] bits;
    int off;
    bits = {1'b1, data, 1'b0};
    off  = 0;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < bw[i]; k++) begin
        rx = (off == glitch) ? 1'b0 : bits[i];
        off++;
        tick();
      end
    end
    rx = 1'b1;
  endtask

  initial begin
    arst_ni = 1'b0; rx = 1'b1; start = 1'b0; abort = 1'b0;
    s_rx = 1'b1; s_start = 1'b0; s_abort = 1'b0;
    repeat (3) tick();
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_error", 32'(error_o), 32'd0);
    chk("reset_div", div_o, 32'd0);
    chk("reset_valid", 32'(div_valid_o), 32'd0);
    arst_ni = 1'b1;
    repeat (2) tick();

    // Exact 100 cycles/bit.
    arm();
    set_bw(100);
    push(1'b1, 32'd100, 1'b1);
    send_frame(8'h55, -1);
    wait_drain(100);
    chk("valid_sticky", 32'(div_valid_o), 32'd1);

    // Uneven bits, T = 803 rounds to 100.
    arm();
    set_bw(100);
    bw[1] = 101; bw[3] = 101; bw[5] = 101;
    push(1'b1, 32'd100, 1'b1);
    send_frame(8'h55, -1);
    wait_drain(100);

    // Slow rate, T = 6944.
    arm();
    set_bw(868);
    push(1'b1, 32'd868, 1'b1);
    send_frame(8'h55, -1);
    wait_drain(100);

    // 0x53 breaks segment tolerance; div kept, valid stays cleared from arm.
    arm();
    set_bw(100);
    push(1'b0, 32'd868, 1'b0);
    send_frame(8'h53, -1);
    wait_drain(100);

    // Too fast: divider 12 below minimum.
    arm();
    set_bw(12);
    push(1'b0, 32'd868, 1'b0);
    send_frame(8'h55, -1);
    wait_drain(100);

    // One-cycle low glitch inside segment 2.
    arm();
    set_bw(100);
    push(1'b0, 32'd868, 1'b0);
    send_frame(8'h55, 350);
    wait_drain(100);

    // Small counter instance: line stuck low times out.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("small_busy_after_arm", 32'(s_busy), 32'd1);
    repeat (2) tick();
    s_rx = 1'b0;
    begin
      exp_t ex;
      ex.is_done = 1'b0; ex.div = 32'd0; ex.valid = 1'b0;
      qs.push_back(ex);
    end
    wait_drain(400);
    s_rx = 1'b1;
    repeat (5) tick();

    // Start together with abort from IDLE stays idle.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy_o), 32'd0);

    // Abort during MEAS: no pulse, divider untouched.
    arm();
    rx = 1'b0;
    repeat (100) tick();
    rx = 1'b1;
    repeat (50) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_div", div_o, 32'd868);
    repeat (300) tick();

    // Asynchronous reset mid-MEAS clears outputs immediately.
    arm();
    rx = 1'b0;
    repeat (60) tick();
    arst_ni = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy_o), 32'd0);
    chk("midreset_done", 32'(done_o), 32'd0);
    chk("midreset_error", 32'(error_o), 32'd0);
    chk("midreset_div", div_o, 32'd0);
    chk("midreset_valid", 32'(div_valid_o), 32'd0);
    rx = 1'b1;
    repeat (2) tick();
    arst_ni = 1'b1;
    repeat (2) tick();

    arm();
    set_bw(50);
    push(1'b1, 32'd50, 1'b1);
    send_frame(8'h55, -1);
    wait_drain(100);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
